// File: rtl/riscv_load_unit_if.sv
// Load-unit bus bundle: load request from execute, data-memory read channel,
// and register-file writeback / error strobes.
interface riscv_load_unit_if #(
    parameter int WORD_LENGTH = 32,
    parameter int REG_ADDR_W  = 5
);
    logic                   ld_valid;
    logic                   ld_ready;
    logic [WORD_LENGTH-1:0] ld_addr;
    logic [2:0]             ld_funct3;
    logic [REG_ADDR_W-1:0]  ld_rd;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [WORD_LENGTH-1:0] mem_req_addr;
    logic                   mem_rsp_valid;
    logic [WORD_LENGTH-1:0] mem_rsp_data;
    logic                   wb_valid;
    logic [REG_ADDR_W-1:0]  wb_rd;
    logic [WORD_LENGTH-1:0] wb_data;
    logic                   err_valid;
    logic                   busy;

    modport slave (
        input  ld_valid, ld_addr, ld_funct3, ld_rd,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output ld_ready, mem_req_valid, mem_req_addr,
        output wb_valid, wb_rd, wb_data, err_valid, busy
    );

    modport master (
        output ld_valid, ld_addr, ld_funct3, ld_rd,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  ld_ready, mem_req_valid, mem_req_addr,
        input  wb_valid, wb_rd, wb_data, err_valid, busy
    );
endinterface

// File: rtl/riscv_load_unit.sv
// Single-outstanding load unit: word-aligned memory read, then byte/half/word
// select and sign/zero extension for register writeback.
//
// state | meaning
// IDLE  | ready for a new load
// REQ   | read request asserted, waiting for mem_req_ready
// WAIT  | request accepted, waiting for mem_rsp_valid
// DONE  | wb_valid strobe for the completed load
// ERR   | err_valid strobe for a misaligned / illegal load
module riscv_load_unit #(
    parameter int WORD_LENGTH = 32,
    parameter int REG_ADDR_W  = 5
) (
    input logic               clk,
    input logic               rst_n,
    riscv_load_unit_if.slave  bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [1:0]             addr_lo_q, addr_lo_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [REG_ADDR_W-1:0]  rd_q, rd_d;
    logic                   mem_req_valid_q, mem_req_valid_d;
    logic [WORD_LENGTH-1:0] mem_req_addr_q, mem_req_addr_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [REG_ADDR_W-1:0]  wb_rd_q, wb_rd_d;
    logic [WORD_LENGTH-1:0] wb_data_q, wb_data_d;
    logic                   err_valid_q, err_valid_d;

    logic                   ld_bad;
    logic [7:0]             byte_sel;
    logic [15:0]            half_sel;
    logic [WORD_LENGTH-1:0] load_ext;

    always_comb begin
        ld_bad = 1'b1;
        case (bus.ld_funct3)
            3'd0, 3'd4: ld_bad = 1'b0;
            3'd1, 3'd5: ld_bad = bus.ld_addr[0];
            3'd2:       ld_bad = (bus.ld_addr[1:0] != 2'b00);
            default:    ld_bad = 1'b1;
        endcase
    end

    // Lane select uses the latched low address bits, not the live request.
    always_comb begin
        byte_sel = bus.mem_rsp_data[{addr_lo_q, 3'b000} +: 8];
        half_sel = bus.mem_rsp_data[{addr_lo_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'd0:    load_ext = {{(WORD_LENGTH-8){byte_sel[7]}}, byte_sel};
            3'd4:    load_ext = {{(WORD_LENGTH-8){1'b0}}, byte_sel};
            3'd1:    load_ext = {{(WORD_LENGTH-16){half_sel[15]}}, half_sel};
            3'd5:    load_ext = {{(WORD_LENGTH-16){1'b0}}, half_sel};
            default: load_ext = bus.mem_rsp_data;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        addr_lo_d       = addr_lo_q;
        funct3_d        = funct3_q;
        rd_d            = rd_q;
        mem_req_valid_d = 1'b0;
        mem_req_addr_d  = mem_req_addr_q;
        wb_valid_d      = 1'b0;
        wb_rd_d         = wb_rd_q;
        wb_data_d       = wb_data_q;
        err_valid_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.ld_valid) begin
                    addr_lo_d = bus.ld_addr[1:0];
                    funct3_d  = bus.ld_funct3;
                    rd_d      = bus.ld_rd;
                    if (ld_bad) begin
                        state_d     = ST_ERR;
                        err_valid_d = 1'b1;
                    end else begin
                        state_d         = ST_REQ;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = {bus.ld_addr[WORD_LENGTH-1:2], 2'b00};
                    end
                end
            end
            ST_REQ: begin
                if (bus.mem_req_ready) state_d = ST_WAIT;
                else                   mem_req_valid_d = 1'b1;
            end
            ST_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    state_d    = ST_DONE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = load_ext;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            addr_lo_q       <= 2'b00;
            funct3_q        <= 3'd0;
            rd_q            <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_data_q       <= '0;
            err_valid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_lo_q       <= addr_lo_d;
            funct3_q        <= funct3_d;
            rd_q            <= rd_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            wb_valid_q      <= wb_valid_d;
            wb_rd_q         <= wb_rd_d;
            wb_data_q       <= wb_data_d;
            err_valid_q     <= err_valid_d;
        end
    end

    assign bus.ld_ready      = (state_q == ST_IDLE);
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = mem_req_addr_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.err_valid     = err_valid_q;
endmodule

// File: tb/tb_riscv_load_unit.sv
// Directed bench for riscv_load_unit: aligned/extended loads, stalls, errors,
// back-to-back acceptance and mid-transaction reset.
module tb_riscv_load_unit;
    logic clk;
    logic rst_n;
    int   chk_cnt;
    int   err_cnt;

    riscv_load_unit_if #(.WORD_LENGTH(32), .REG_ADDR_W(5)) lu_if ();

    riscv_load_unit #(.WORD_LENGTH(32), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (lu_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ld_ready"}, 32'(lu_if.ld_ready), 32'd1);
        chk({tag, "_busy"},     32'(lu_if.busy), 32'd0);
        chk({tag, "_wb_valid"}, 32'(lu_if.wb_valid), 32'd0);
        chk({tag, "_err"},      32'(lu_if.err_valid), 32'd0);
        chk({tag, "_req"},      32'(lu_if.mem_req_valid), 32'd0);
    endtask

    // Accept in the current cycle, stall REQ rdy_wait cycles (with spurious
    // responses that must be ignored), respond rsp_wait cycles into WAIT.
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [4:0] rd, input int rdy_wait, input int rsp_wait,
                            input logic [31:0] rsp, input logic [31:0] exp_data);
        lu_if.ld_valid  = 1'b1;
        lu_if.ld_funct3 = f3;
        lu_if.ld_addr   = addr;
        lu_if.ld_rd     = rd;
        chk({tag, "_accept_ready"}, 32'(lu_if.ld_ready), 32'd1);
        tick();
        lu_if.ld_valid = 1'b0;
        for (int i = 0; i <= rdy_wait; i++) begin
            chk({tag, "_req_valid"}, 32'(lu_if.mem_req_valid), 32'd1);
            chk({tag, "_req_addr"},  lu_if.mem_req_addr, {addr[31:2], 2'b00});
            chk({tag, "_req_ready_low"}, 32'(lu_if.ld_ready), 32'd0);
            lu_if.mem_req_ready = (i == rdy_wait);
            lu_if.mem_rsp_valid = 1'b1;
            lu_if.mem_rsp_data  = 32'hDEAD_BEEF;
            tick();
        end
        lu_if.mem_req_ready = 1'b0;
        for (int j = 0; j <= rsp_wait; j++) begin
            chk({tag, "_wait_req"}, 32'(lu_if.mem_req_valid), 32'd0);
            chk({tag, "_wait_wb"},  32'(lu_if.wb_valid), 32'd0);
            lu_if.mem_rsp_valid = (j == rsp_wait);
            lu_if.mem_rsp_data  = (j == rsp_wait) ? rsp : 32'h5A5A_5A5A;
            tick();
        end
        lu_if.mem_rsp_valid = 1'b0;
        chk({tag, "_wb_valid"}, 32'(lu_if.wb_valid), 32'd1);
        chk({tag, "_wb_data"},  lu_if.wb_data, exp_data);
        chk({tag, "_wb_rd"},    32'(lu_if.wb_rd), 32'(rd));
        chk({tag, "_done_err"}, 32'(lu_if.err_valid), 32'd0);
        tick();
        check_idle({tag, "_after"});
    endtask

    task automatic run_err(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] prev_data);
        lu_if.ld_valid  = 1'b1;
        lu_if.ld_funct3 = f3;
        lu_if.ld_addr   = addr;
        lu_if.ld_rd     = 5'd31;
        chk({tag, "_accept_ready"}, 32'(lu_if.ld_ready), 32'd1);
        tick();
        lu_if.ld_valid = 1'b0;
        chk({tag, "_err_valid"}, 32'(lu_if.err_valid), 32'd1);
        chk({tag, "_no_req"},    32'(lu_if.mem_req_valid), 32'd0);
        chk({tag, "_no_wb"},     32'(lu_if.wb_valid), 32'd0);
        chk({tag, "_wb_hold"},   lu_if.wb_data, prev_data);
        tick();
        check_idle({tag, "_after"});
    endtask

    initial begin
        chk_cnt = 0;
        err_cnt = 0;
        rst_n               = 1'b0;
        lu_if.ld_valid      = 1'b0;
        lu_if.ld_addr       = '0;
        lu_if.ld_funct3     = '0;
        lu_if.ld_rd         = '0;
        lu_if.mem_req_ready = 1'b0;
        lu_if.mem_rsp_valid = 1'b0;
        lu_if.mem_rsp_data  = '0;
        #12;
        check_idle("reset");
        chk("reset_wb_data", lu_if.wb_data, 32'd0);
        chk("reset_req_addr", lu_if.mem_req_addr, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        run_load("lb",   3'd0, 32'h0000_1003, 5'd3, 0, 0, 32'h80FF_1234, 32'hFFFF_FF80);
        run_load("lbu",  3'd4, 32'h0000_1003, 5'd4, 0, 0, 32'h80FF_1234, 32'h0000_0080);
        run_load("lhu",  3'd5, 32'h0000_1002, 5'd5, 0, 0, 32'h80FF_1234, 32'h0000_80FF);
        run_load("lh",   3'd1, 32'h0000_1002, 5'd6, 0, 0, 32'h80FF_1234, 32'hFFFF_80FF);
        run_load("lb1",  3'd0, 32'h0000_1001, 5'd8, 0, 0, 32'h80FF_1234, 32'h0000_0012);
        run_load("lh0",  3'd1, 32'h0000_1000, 5'd2, 0, 0, 32'h80FF_1234, 32'h0000_1234);
        run_load("lw",   3'd2, 32'h0000_2000, 5'd10, 3, 1, 32'hCAFE_F00D, 32'hCAFE_F00D);

        run_err("err_lh_odd", 3'd1, 32'h0000_1001, 32'hCAFE_F00D);
        run_err("err_lw_mis", 3'd2, 32'h0000_1002, 32'hCAFE_F00D);
        run_err("err_f3_3",   3'd3, 32'h0000_1000, 32'hCAFE_F00D);
        run_err("err_f3_7",   3'd7, 32'h0000_1000, 32'hCAFE_F00D);

        // Back-to-back with ld_valid held high across both loads.
        lu_if.ld_valid  = 1'b1;
        lu_if.ld_funct3 = 3'd2;
        lu_if.ld_addr   = 32'h0000_0040;
        lu_if.ld_rd     = 5'd7;
        chk("b2b_t0_ready", 32'(lu_if.ld_ready), 32'd1);
        tick();
        chk("b2b_t1_ready", 32'(lu_if.ld_ready), 32'd0);
        lu_if.ld_addr       = 32'h0000_0044;
        lu_if.ld_rd         = 5'd9;
        lu_if.mem_req_ready = 1'b1;
        tick();
        chk("b2b_t2_ready", 32'(lu_if.ld_ready), 32'd0);
        lu_if.mem_req_ready = 1'b0;
        lu_if.mem_rsp_valid = 1'b1;
        lu_if.mem_rsp_data  = 32'h1111_1111;
        tick();
        lu_if.mem_rsp_valid = 1'b0;
        chk("b2b_t3_ready", 32'(lu_if.ld_ready), 32'd0);
        chk("b2b_t3_wb",    32'(lu_if.wb_valid), 32'd1);
        chk("b2b_t3_rd",    32'(lu_if.wb_rd), 32'd7);
        chk("b2b_t3_data",  lu_if.wb_data, 32'h1111_1111);
        tick();
        chk("b2b_t4_ready", 32'(lu_if.ld_ready), 32'd1);
        tick();
        lu_if.ld_valid = 1'b0;
        chk("b2b_t5_req",  32'(lu_if.mem_req_valid), 32'd1);
        chk("b2b_t5_addr", lu_if.mem_req_addr, 32'h0000_0044);
        lu_if.mem_req_ready = 1'b1;
        tick();
        lu_if.mem_req_ready = 1'b0;
        lu_if.mem_rsp_valid = 1'b1;
        lu_if.mem_rsp_data  = 32'h2222_2222;
        tick();
        lu_if.mem_rsp_valid = 1'b0;
        chk("b2b_t7_wb",   32'(lu_if.wb_valid), 32'd1);
        chk("b2b_t7_rd",   32'(lu_if.wb_rd), 32'd9);
        chk("b2b_t7_data", lu_if.wb_data, 32'h2222_2222);
        tick();
        check_idle("b2b_end");

        // Reset while in WAIT, then a stale response after release.
        lu_if.ld_valid  = 1'b1;
        lu_if.ld_funct3 = 3'd2;
        lu_if.ld_addr   = 32'h0000_3000;
        lu_if.ld_rd     = 5'd12;
        tick();
        lu_if.ld_valid      = 1'b0;
        lu_if.mem_req_ready = 1'b1;
        tick();
        lu_if.mem_req_ready = 1'b0;
        chk("rst_in_wait_busy", 32'(lu_if.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_idle("rst_async");
        chk("rst_async_wb_data", lu_if.wb_data, 32'd0);
        chk("rst_async_wb_rd",   32'(lu_if.wb_rd), 32'd0);
        chk("rst_async_addr",    lu_if.mem_req_addr, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        lu_if.mem_rsp_valid = 1'b1;
        lu_if.mem_rsp_data  = 32'h7777_7777;
        tick();
        lu_if.mem_rsp_valid = 1'b0;
        check_idle("rst_stale_rsp");
        chk("rst_stale_wb_data", lu_if.wb_data, 32'd0);
        run_load("post_rst", 3'd4, 32'h0000_3001, 5'd13, 1, 0, 32'h0102_A304, 32'h0000_00A3);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/riscv_load_unit.md
# riscv_load_unit

Load-side counterpart of the store data mask: accepts a decoded load (address, funct3, destination register), issues one word-aligned read on the data-memory request/response interface, then selects, aligns and sign- or zero-extends the returned byte/halfword/word before presenting it to register-file writeback. Sits between the execute stage and data memory; one load in flight at a time.

## Interface
- WORD_LENGTH, 32, datapath and address width
- REG_ADDR_W, 5, register index width

- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- ld_valid  input  1  load request present
- ld_ready  output  1  unit can accept (high only in IDLE)
- ld_addr  input  WORD_LENGTH  byte address
- ld_funct3  input  3  0=LB,1=LH,2=LW,4=LBU,5=LHU; others illegal
- ld_rd  input  REG_ADDR_W  destination register
- mem_req_valid  output  1  read request
- mem_req_ready  input  1  memory accepts request
- mem_req_addr  output  WORD_LENGTH  {ld_addr[WORD_LENGTH-1:2], 2'b00}
- mem_rsp_valid  input  1  read data valid
- mem_rsp_data  input  WORD_LENGTH  word at mem_req_addr, little-endian
- wb_valid  output  1  one-cycle writeback strobe
- wb_rd  output  REG_ADDR_W  destination register
- wb_data  output  WORD_LENGTH  extended load result
- err_valid  output  1  one-cycle strobe: misaligned or illegal funct3
- busy  output  1  high in any state but IDLE

## Operation
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE: ld_ready=1. On ld_valid: latch addr, funct3, rd. Illegal funct3, LH/LHU with addr[0]=1, or LW with addr[1:0]!=0 -> ERR (no memory request). Otherwise -> REQ.
- REQ: mem_req_valid=1, mem_req_addr stable from latched addr. Hold until mem_req_ready; then -> WAIT. mem_rsp_valid in REQ is ignored.
- WAIT: on mem_rsp_valid, compute result into wb_data register, -> DONE.
- Selection: byte = mem_rsp_data[8*addr[1:0] +: 8]; halfword = mem_rsp_data[16*addr[1] +: 16]; word = full data.
- Extension: LB/LH replicate bit 7/15 into upper bits; LBU/LHU zero-fill; LW unchanged.
- DONE: wb_valid=1, wb_rd=latched rd, -> IDLE.
- ERR: err_valid=1, wb_valid=0, -> IDLE. wb_data holds previous value.
- No request queuing: ld_valid outside IDLE is not accepted (ld_ready=0).

## Timing
- Reset (async assert, sync release on clk): state=IDLE; mem_req_valid=0, mem_req_addr=0, wb_valid=0, wb_rd=0, wb_data=0, err_valid=0, busy=0, ld_ready=1. Reset mid-transaction abandons it; any later mem_rsp_valid is ignored in IDLE.
- ld_ready is combinational from state only (no dependence on ld_valid).
- Accept at cycle T -> mem_req_valid from T+1. With mem_req_ready at T+1 and mem_rsp_valid at T+2, wb_valid at T+3. Minimum load latency 3 cycles accept-to-writeback; next accept at T+4 earliest (IDLE at T+4).
- mem_req_ready stalls extend REQ cycle-for-cycle; mem_rsp_valid delay extends WAIT.
- Error path: accept at T -> err_valid at T+1, IDLE at T+2; mem_req_valid never asserted.
- wb_valid and err_valid never high together; each exactly one cycle per load.
- All outputs registered except ld_ready and busy (decoded from state register).

## Test plan
- LB addr=0x1003, rsp 0x80FF1234, ready immediate -> mem_req_addr=0x1000, wb_data=0xFFFFFF80, wb_valid at T+3.
- LBU same stimulus -> wb_data=0x00000080; LHU addr=0x1002 rsp 0x80FF1234 -> 0x000080FF; LH -> 0xFFFF80FF.
- LW addr=0x2000, mem_req_ready low 3 cycles, rsp 2 cycles after handshake -> mem_req_valid held 4 cycles with stable addr, wb_data=rsp word, wb_valid once at T+7.
- LH addr=0x1001, LW addr=0x1002, funct3=3 -> err_valid at T+1, no mem_req_valid, no wb_valid.
- ld_valid held high continuously with back-to-back loads -> ld_ready low T+1..T+3, second accept at T+4, rd values distinct in wb_rd.
- rst_n asserted during WAIT, late mem_rsp_valid after release -> all outputs at reset values, no wb_valid, next load completes normally.
